// File: rtl/spi_nor_flash_responder.sv
// SPI mode-0 NOR flash read responder (READ 0x03) backed by a byte-wide memory port.
// Define SPI_FLASH_RESPONDER_FAST_READ_EN to also accept FAST_READ 0x0B with DUMMY_CYCLES dummy clocks.
module spi_nor_flash_responder #(
  parameter int ADDR_W       = 24,
  parameter int DUMMY_CYCLES = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_valid,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              underrun
);

`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
`else
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;
`endif

  state_t      state;
  logic        cs_s1, cs_s2;
  logic        sclk_s1, sclk_s2, sclk_d;
  logic        mosi_s1, mosi_s2;
  logic [4:0]  bit_cnt;
  logic [22:0] shift_in;
  logic [23:0] addr_cnt;
  logic [7:0]  pf_data;
  logic        pf_valid;
  logic [6:0]  out_shift;
  logic [2:0]  out_cnt;
  logic        issue_pending;
  logic        stale;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
  logic        fast;
  logic [15:0] dummy_cnt;
`endif

  logic        sclk_rise;
  logic        sclk_fall;
  logic [7:0]  cmd_byte;
  logic [23:0] addr_word;
  logic [23:0] addr_next;

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;
  assign cmd_byte  = {shift_in[6:0], mosi_s2};
  assign addr_word = {shift_in[22:0], mosi_s2};
  assign addr_next = addr_cnt + 24'd1;
  assign busy      = ~cs_s2;

  // A request still in flight when CS rises is marked stale so its data is dropped,
  // and a new frame waits for it (issue_pending) to keep one request outstanding.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      cs_s1         <= 1'b1;
      cs_s2         <= 1'b1;
      sclk_s1       <= 1'b0;
      sclk_s2       <= 1'b0;
      sclk_d        <= 1'b0;
      mosi_s1       <= 1'b0;
      mosi_s2       <= 1'b0;
      bit_cnt       <= '0;
      shift_in      <= '0;
      addr_cnt      <= '0;
      pf_data       <= '0;
      pf_valid      <= 1'b0;
      out_shift     <= '0;
      out_cnt       <= '0;
      issue_pending <= 1'b0;
      stale         <= 1'b0;
      spi_miso      <= 1'b0;
      spi_miso_oe   <= 1'b0;
      mem_addr      <= '0;
      mem_valid     <= 1'b0;
      underrun      <= 1'b0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
      fast          <= 1'b0;
      dummy_cnt     <= '0;
`endif
    end else begin
      cs_s1   <= spi_cs;
      cs_s2   <= cs_s1;
      sclk_s1 <= spi_sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;

      if (mem_valid && mem_ready) begin
        mem_valid <= 1'b0;
        if (stale) begin
          stale <= 1'b0;
        end else begin
          pf_data  <= mem_rdata;
          pf_valid <= 1'b1;
        end
      end

      if (cs_s2) begin
        state         <= IDLE;
        spi_miso      <= 1'b0;
        spi_miso_oe   <= 1'b0;
        bit_cnt       <= '0;
        out_cnt       <= '0;
        pf_valid      <= 1'b0;
        issue_pending <= 1'b0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
        dummy_cnt     <= '0;
`endif
        if (mem_valid && !mem_ready)
          stale <= 1'b1;
      end else begin
        if (issue_pending && !mem_valid) begin
          mem_valid     <= 1'b1;
          mem_addr      <= addr_cnt[ADDR_W-1:0];
          issue_pending <= 1'b0;
        end

        case (state)
          IDLE: begin
            state    <= CMD;
            bit_cnt  <= '0;
            underrun <= 1'b0;
          end

          CMD: if (sclk_rise) begin
            shift_in <= {shift_in[21:0], mosi_s2};
            bit_cnt  <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
              fast    <= (cmd_byte == 8'h0B);
              if (cmd_byte == 8'h03 || cmd_byte == 8'h0B)
`else
              if (cmd_byte == 8'h03)
`endif
                state <= ADDR;
              else
                state <= IGNORE;
            end
          end

          ADDR: if (sclk_rise) begin
            shift_in <= {shift_in[21:0], mosi_s2};
            bit_cnt  <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd23) begin
              bit_cnt  <= '0;
              addr_cnt <= addr_word;
              out_cnt  <= '0;
              if (!mem_valid) begin
                mem_valid <= 1'b1;
                mem_addr  <= addr_word[ADDR_W-1:0];
              end else begin
                issue_pending <= 1'b1;
              end
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
              state <= (fast && DUMMY_CYCLES > 0) ? DUMMY : DATA;
`else
              state <= DATA;
`endif
            end
          end

`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
          DUMMY: if (sclk_rise) begin
            dummy_cnt <= dummy_cnt + 16'd1;
            if (dummy_cnt == 16'(DUMMY_CYCLES - 1)) begin
              dummy_cnt <= '0;
              state     <= DATA;
            end
          end
`endif

          // First falling edge of each byte consumes the prefetch (or 0xFF on underrun).
          DATA: if (sclk_fall) begin
            out_cnt <= out_cnt + 3'd1;
            if (out_cnt == 3'd0) begin
              spi_miso_oe <= 1'b1;
              if (pf_valid) begin
                out_shift <= pf_data[6:0];
                spi_miso  <= pf_data[7];
                pf_valid  <= 1'b0;
                addr_cnt  <= addr_next;
                mem_valid <= 1'b1;
                mem_addr  <= addr_next[ADDR_W-1:0];
              end else begin
                out_shift <= 7'h7F;
                spi_miso  <= 1'b1;
                underrun  <= 1'b1;
              end
            end else begin
              spi_miso  <= out_shift[6];
              out_shift <= {out_shift[5:0], 1'b0};
            end
          end

          IGNORE: begin
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
